// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared types and constants for the PWM core.
//   pwm_state_e     : run-control FSM states (IDLE, RUN, STOP)
//   default_period  : all-ones period loaded on reset for a RES-bit counter
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } pwm_state_e;

  // Largest period a res-bit counter can express (2**res - 1); res <= 32.
  function automatic logic [31:0] default_period(input int unsigned res);
    return 32'((64'd1 << res) - 64'd1);
  endfunction

endpackage

// File: rtl/pwm_shadow_reg.sv
// pwm_shadow_reg -- period/duty load handshake with a one-deep shadow.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   load_valid_i      : source offers period_i/duty_i
//   period_i, duty_i  : offered pair (period minus one, high time in ticks)
//   idle_i            : core is IDLE, so the pair may go straight to active
//   wrap_i            : core is wrapping this clock; pending pair goes live
//   load_ready_o      : no shadow pair pending, a new pair can be accepted
//   period_act_o      : active period used by the counter
//   duty_act_o        : active duty used by the comparator
module pwm_shadow_reg
  import pwm_pkg::*;
#(
  parameter int unsigned RES = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_valid_i,
  input  logic [RES-1:0] period_i,
  input  logic [RES:0]   duty_i,
  input  logic           idle_i,
  input  logic           wrap_i,
  output logic           load_ready_o,
  output logic [RES-1:0] period_act_o,
  output logic [RES:0]   duty_act_o
);

  localparam logic [RES-1:0] PERIOD_RST = RES'(default_period(RES));

  logic           pending_q, pending_d;
  logic [RES-1:0] period_act_q, period_act_d, period_sh_q;
  logic [RES:0]   duty_act_q, duty_act_d, duty_sh_q;
  logic           xfer;

  // A transfer needs an empty shadow; offers while pending are ignored.
  assign xfer = load_valid_i & ~pending_q;

  always_comb begin
    pending_d    = pending_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    // The wrap consumes the pair already waiting before any new capture.
    if (wrap_i && pending_q) begin
      period_act_d = period_sh_q;
      duty_act_d   = duty_sh_q;
      pending_d    = 1'b0;
    end
    if (xfer) begin
      if (idle_i) begin
        period_act_d = period_i;
        duty_act_d   = duty_i;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q    <= 1'b0;
      period_act_q <= PERIOD_RST;
      duty_act_q   <= '0;
    end else begin
      pending_q    <= pending_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
    end
  end

  // Shadow contents are only meaningful while pending_q is set.
  always_ff @(posedge clk) begin
    if (xfer && !idle_i) begin
      period_sh_q <= period_i;
      duty_sh_q   <= duty_i;
    end
  end

  assign load_ready_o = ~pending_q;
  assign period_act_o = period_act_q;
  assign duty_act_o   = duty_act_q;

endmodule

// File: rtl/pwm_core.sv
// pwm_core -- tick-stepped PWM generator with shadowed period/duty loads.
// Ports:
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   tick         : one-clk step strobe from the upstream prescaler
//   enable       : run request
//   period_in    : requested period minus one, in ticks
//   duty_in      : requested high time, in ticks
//   load_valid   : new period/duty pair offered
//   load_ready   : pair can be accepted
//   pwm_out      : registered PWM waveform (inverted when POLARITY=1)
//   period_done  : one-clk pulse the clock after each wrap
//   busy         : FSM is not IDLE
module pwm_core
  import pwm_pkg::*;
#(
  parameter int unsigned RES      = 8,
  parameter int unsigned POLARITY = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           enable,
  input  logic [RES-1:0] period_in,
  input  logic [RES:0]   duty_in,
  input  logic           load_valid,
  output logic           load_ready,
  output logic           pwm_out,
  output logic           period_done,
  output logic           busy
);

  localparam logic INACT = (POLARITY != 0);

  pwm_state_e     state_q, state_d;
  logic [RES-1:0] cnt_q, cnt_d;
  logic           pwm_q, pwm_d;
  logic           done_q;
  logic           busy_q;
  logic           wrap;
  logic           idle;
  logic [RES-1:0] period_act;
  logic [RES:0]   duty_act;

  assign idle = (state_q == ST_IDLE);
  assign wrap = !idle && tick && (cnt_q == period_act);

  pwm_shadow_reg #(
    .RES (RES)
  ) u_shadow (
    .clk          (clk),
    .reset        (reset),
    .load_valid_i (load_valid),
    .period_i     (period_in),
    .duty_i       (duty_in),
    .idle_i       (idle),
    .wrap_i       (wrap),
    .load_ready_o (load_ready),
    .period_act_o (period_act),
    .duty_act_o   (duty_act)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_STOP;
      // Re-enable wins over a coinciding wrap: the waveform keeps running.
      ST_STOP: begin
        if (enable)    state_d = ST_RUN;
        else if (wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_d = cnt_q;
    if (idle)      cnt_d = '0;
    else if (wrap) cnt_d = '0;
    else if (tick) cnt_d = cnt_q + RES'(1);

    // Compare uses the current count, so pwm_out lags cnt by one clk.
    // duty is one bit wider so duty > period gives a constant active level.
    pwm_d = !idle && ({1'b0, cnt_q} < duty_act);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pwm_q   <= INACT;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d ^ INACT;
      done_q  <= wrap;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign pwm_out     = pwm_q;
  assign period_done = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pwm_core.sv
// tb_pwm_core -- self-checking bench for pwm_core (RES=8, POLARITY=0).
// A monitor measures every window between period_done pulses (length in clk
// and number of clks with pwm_out high) and compares it to the record at the
// head of a scoreboard queue that the stimulus fills as it starts each run.
module tb_pwm_core;

  localparam int RES = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           tick;
  logic           enable;
  logic [RES-1:0] period_in;
  logic [RES:0]   duty_in;
  logic           load_valid;
  logic           load_ready;
  logic           pwm_out;
  logic           period_done;
  logic           busy;

  pwm_core #(
    .RES      (RES),
    .POLARITY (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .enable      (enable),
    .period_in   (period_in),
    .duty_in     (duty_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int duty;
    int div;
    int len;
    int hi;
  } vec_t;

  typedef struct {
    bit    chk;
    int    len;
    int    hi;
    string tag;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  tick_div = 4;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Tick generator: one-clk strobe every tick_div clocks.
  initial begin
    int tcnt = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tcnt >= tick_div - 1) begin
        tick = 1'b1;
        tcnt = 0;
      end else begin
        tick = 1'b0;
        tcnt++;
      end
    end
  end

  // Window monitor / scoreboard consumer.
  initial begin
    int  len = 0;
    int  hi  = 0;
    sb_t rec;
    forever begin
      @(negedge clk);
      if (period_done === 1'b1) begin
        if (sb.size() > 0) begin
          rec = sb.pop_front();
          if (rec.chk) begin
            check({rec.tag, " period clks"}, len, rec.len);
            check({rec.tag, " high clks"}, hi, rec.hi);
          end
        end
        len = 1;
        hi  = int'(pwm_out === 1'b1);
      end else begin
        len++;
        hi += int'(pwm_out === 1'b1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit chk, input int len, input int hi, input string tag);
    sb_t r;
    r.chk = chk; r.len = len; r.hi = hi; r.tag = tag;
    sb.push_back(r);
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      step();
      if (period_done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_fail++;
      $display("FAIL %s: period_done timeout, got none, expected pulse within 2000 clk", name);
    end
  endtask

  task automatic wait_idle(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      step();
      if (busy === 1'b0) got = 1'b1;
    end
    if (!got) begin
      n_fail++;
      $display("FAIL %s: busy timeout, got 1, expected 0 within 2000 clk", name);
    end
  endtask

  // Returns #1 after the clock edge that consumed the n-th tick.
  task automatic wait_ticks(input int n);
    logic t;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 64; k++) begin
        @(posedge clk);
        t = tick;
        #1;
        if (t) break;
      end
    end
  endtask

  task automatic load_pair(input int p, input int d);
    period_in  = RES'(p);
    duty_in    = (RES+1)'(d);
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    bit   bad;

    vecs[0] = '{period: 9, duty: 3,  div: 4, len: 40, hi: 12};
    vecs[1] = '{period: 9, duty: 0,  div: 4, len: 40, hi: 0};
    vecs[2] = '{period: 9, duty: 10, div: 4, len: 40, hi: 40};
    vecs[3] = '{period: 0, duty: 1,  div: 4, len: 4,  hi: 4};
    vecs[4] = '{period: 4, duty: 2,  div: 1, len: 5,  hi: 2};
    vecs[5] = '{period: 9, duty: 3,  div: 1, len: 10, hi: 3};

    reset      = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    period_in  = '0;
    duty_in    = '0;
    repeat (3) step();
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset period_done", int'(period_done), 0);
    check("reset busy", int'(busy), 0);
    check("reset load_ready", int'(load_ready), 1);
    reset = 1'b0;
    step();

    // Table-driven steady-state waveforms.
    for (int i = 0; i < 6; i++) begin
      tick_div = vecs[i].div;
      load_pair(vecs[i].period, vecs[i].duty);
      check($sformatf("vec%0d load_ready after idle load", i), int'(load_ready), 1);
      enable = 1'b1;
      push(1'b0, 0, 0, "");
      for (int j = 0; j < 3; j++) push(1'b1, vecs[i].len, vecs[i].hi, $sformatf("vec%0d", i));
      for (int j = 0; j < 4; j++) wait_done($sformatf("vec%0d", i));
      enable = 1'b0;
      wait_idle($sformatf("vec%0d stop", i));
    end

    // Mid-period load, plus an ignored second offer while pending.
    tick_div = 4;
    load_pair(9, 3);
    enable = 1'b1;
    push(1'b0, 0, 0, "");
    push(1'b1, 40, 12, "old pair completes");
    push(1'b1, 20, 8, "new pair first");
    push(1'b1, 20, 8, "new pair second");
    wait_done("midload first");
    wait_ticks(5);
    check("midload ready before offer", int'(load_ready), 1);
    load_pair(4, 2);
    check("midload ready after capture", int'(load_ready), 0);
    period_in  = RES'(7);
    duty_in    = (RES+1)'(7);
    load_valid = 1'b1;
    repeat (3) step();
    load_valid = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (period_done === 1'b1) break;
      if (load_ready !== 1'b0) bad = 1'b1;
      step();
    end
    check("midload ready low until wrap", int'(bad), 0);
    check("midload ready back after wrap", int'(load_ready), 1);
    wait_done("midload new1");
    wait_done("midload new2");
    enable = 1'b0;
    wait_idle("midload stop");

    // Enable drop at cnt=5: finish the period, then IDLE.
    load_pair(9, 3);
    enable = 1'b1;
    push(1'b0, 0, 0, "");
    push(1'b1, 40, 12, "stop period");
    wait_done("drop first");
    wait_ticks(5);
    enable = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (period_done === 1'b1) break;
      if (busy !== 1'b1) bad = 1'b1;
    end
    check("drop busy held until wrap", int'(bad), 0);
    check("drop busy at wrap", int'(busy), 0);
    bad = 1'b0;
    repeat (6) begin
      step();
      if (pwm_out !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("drop idle pwm low", int'(bad), 0);

    // Drop at cnt=5, re-enable at cnt=7: counting is uninterrupted.
    enable = 1'b1;
    push(1'b0, 0, 0, "");
    push(1'b1, 40, 12, "reenable period");
    push(1'b1, 40, 12, "after reenable");
    wait_done("reen first");
    wait_ticks(5);
    enable = 1'b0;
    wait_ticks(2);
    check("reen busy in stop", int'(busy), 1);
    enable = 1'b1;
    wait_done("reen wrap");
    wait_done("reen next");
    enable = 1'b0;
    wait_idle("reen stop");

    // Reset at cnt=6 with a pending pair.
    enable = 1'b1;
    push(1'b0, 0, 0, "");
    wait_done("rst first");
    wait_ticks(5);
    period_in  = RES'(4);
    duty_in    = (RES+1)'(2);
    load_valid = 1'b1;
    wait_ticks(1);
    load_valid = 1'b0;
    check("rst pending before reset", int'(load_ready), 0);
    sb.delete();
    #2 reset = 1'b1;
    #1;
    check("rst busy", int'(busy), 0);
    check("rst pwm_out", int'(pwm_out), 0);
    check("rst period_done", int'(period_done), 0);
    check("rst load_ready", int'(load_ready), 1);
    enable = 1'b0;
    step();
    reset = 1'b0;
    step();
    tick_div = 1;
    enable = 1'b1;
    push(1'b0, 0, 0, "");
    push(1'b1, 256, 0, "post-reset defaults");
    wait_done("post-reset first");
    wait_done("post-reset second");
    enable = 1'b0;
    @(negedge clk);
    #1;
    check("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
